vball_sprite_linebuf: RTL and testbench

//  Double-buffered sprite line buffer, downstream of the video timing generator (consumes hcount/vcount/hb).

---
 rtl/vball_sprite_linebuf_if.sv | 23 ++
 rtl/vball_sprite_linebuf.sv | 193 +++++++++++++++++++
 tb/tb_vball_sprite_linebuf.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vball_sprite_linebuf_if.sv
// Renderer-side bus of the sprite line buffer: line request (line_start/line_y)
// going out to the sprite renderer and the pixel-write handshake coming back.
// master = sprite renderer, slave = line buffer.
interface vball_sprite_linebuf_if #(
  parameter int PIXW = 8
);
  logic            line_start;
  logic [8:0]      line_y;
  logic            wr_valid;
  logic            wr_ready;
  logic [8:0]      wr_x;
  logic [PIXW-1:0] wr_pix;

  modport master (
    output wr_valid, wr_x, wr_pix,
    input  wr_ready, line_start, line_y
  );

  modport slave (
    input  wr_valid, wr_x, wr_pix,
    output wr_ready, line_start, line_y
  );
endinterface

// File: rtl/vball_sprite_linebuf.sv
// Double-buffered sprite line buffer. The renderer fills the back bank with the
// next line while the front bank is scanned out (and cleared as it is read).
// Banks swap on every rising edge of hb.
// Optional feature macro: VBALL_SPRITE_PRIORITY_EN
//   undefined: last opaque write to an x wins, one write per cycle
//   defined:   first opaque write wins via read-modify-write, one write per two cycles
module vball_sprite_linebuf #(
  parameter int HACTIVE = 240,
  parameter int VACTIVE = 240,
  parameter int VTOTAL  = 262,
  parameter int PIXW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            hcount,
  input  logic [8:0]            vcount,
  input  logic                  hb,
  input  logic                  flip,
  vball_sprite_linebuf_if.slave rnd,
  output logic [PIXW-1:0]       pix_out,
  output logic                  pix_opaque
);

  localparam logic [8:0] HACT  = 9'(HACTIVE);
  localparam logic [8:0] HLAST = 9'(HACTIVE - 1);
  localparam logic [8:0] VACT  = 9'(VACTIVE);
  localparam logic [8:0] VLAST = 9'(VTOTAL - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [7:0]      clear_addr;
  logic            sel;
  logic            hb_d;

  logic [PIXW-1:0] bank0 [256];
  logic [PIXW-1:0] bank1 [256];

  logic            swap_req;
  logic            do_swap;
  logic            accept;
  logic            wr_keep;
  logic [8:0]      next_y;
  logic [8:0]      rd_raw;
  logic [7:0]      rd_addr;
  logic            rd_en;
  logic [PIXW-1:0] front_pix;

  logic            bk_we;
  logic [7:0]      bk_addr;
  logic [PIXW-1:0] bk_data;

  logic            b0_we, b1_we;
  logic [7:0]      b0_addr, b1_addr;
  logic [PIXW-1:0] b0_data, b1_data;

`ifdef VBALL_SPRITE_PRIORITY_EN
  logic            rmw_busy;
  logic            rmw_ok;
  logic            swap_pend;
  logic [7:0]      rmw_x;
  logic [PIXW-1:0] rmw_pix;
  logic [PIXW-1:0] back_pix;
`endif

  // Swap detection, read addressing and the renderer write decode.
  always_comb begin
    swap_req  = hb && !hb_d && (state == RUN);
    next_y    = (vcount == VLAST) ? 9'd0 : vcount + 9'd1;
    rd_raw    = flip ? (HLAST - hcount) : hcount;
    rd_addr   = rd_raw[7:0];
    rd_en     = (state == RUN) && !hb && !reset;
    front_pix = sel ? bank1[rd_addr] : bank0[rd_addr];
    wr_keep   = (rnd.wr_pix[3:0] != 4'd0) && (rnd.wr_x < HACT);
`ifdef VBALL_SPRITE_PRIORITY_EN
    do_swap      = (swap_req && !rmw_busy) || swap_pend;
    rnd.wr_ready = (state == RUN) && !reset && !rmw_busy && !swap_req && !swap_pend;
    back_pix     = sel ? bank0[rmw_x] : bank1[rmw_x];
    bk_we        = rmw_busy && rmw_ok && (back_pix[3:0] == 4'd0) && !reset;
    bk_addr      = rmw_x;
    bk_data      = rmw_pix;
`else
    do_swap      = swap_req;
    rnd.wr_ready = (state == RUN) && !reset && !swap_req;
    bk_we        = rnd.wr_valid && rnd.wr_ready && wr_keep;
    bk_addr      = rnd.wr_x[7:0];
    bk_data      = rnd.wr_pix;
`endif
    accept = rnd.wr_valid && rnd.wr_ready;
  end

  // Route clear, clear-after-read and renderer writes to the right bank.
  always_comb begin
    b0_we   = 1'b0;
    b1_we   = 1'b0;
    b0_addr = clear_addr;
    b1_addr = clear_addr;
    b0_data = '0;
    b1_data = '0;
    if (state == CLEAR) begin
      b0_we = 1'b1;
      b1_we = 1'b1;
    end else begin
      if (rd_en) begin
        if (sel) begin
          b1_we   = 1'b1;
          b1_addr = rd_addr;
        end else begin
          b0_we   = 1'b1;
          b0_addr = rd_addr;
        end
      end
      if (bk_we) begin
        if (sel) begin
          b0_we   = 1'b1;
          b0_addr = bk_addr;
          b0_data = bk_data;
        end else begin
          b1_we   = 1'b1;
          b1_addr = bk_addr;
          b1_data = bk_data;
        end
      end
    end
  end

  // Bank 0 storage.
  always_ff @(posedge clk) begin
    if (b0_we) bank0[b0_addr] <= b0_data;
  end

  // Bank 1 storage.
  always_ff @(posedge clk) begin
    if (b1_we) bank1[b1_addr] <= b1_data;
  end

  // Control FSM: clear both banks after reset, then swap banks and scan out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clear_addr <= 8'd0;
      sel        <= 1'b0;
      hb_d       <= 1'b1;
      pix_out    <= '0;
      pix_opaque <= 1'b0;
      rnd.line_start <= 1'b0;
      rnd.line_y     <= 9'd0;
`ifdef VBALL_SPRITE_PRIORITY_EN
      rmw_busy  <= 1'b0;
      rmw_ok    <= 1'b0;
      swap_pend <= 1'b0;
      rmw_x     <= 8'd0;
      rmw_pix   <= '0;
`endif
    end else begin
      hb_d           <= hb;
      rnd.line_start <= 1'b0;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + 8'd1;
          pix_out    <= '0;
          pix_opaque <= 1'b0;
          if (clear_addr == 8'hFF) state <= RUN;
        end
        RUN: begin
          if (do_swap) begin
            sel            <= ~sel;
            rnd.line_y     <= next_y;
            rnd.line_start <= (next_y < VACT);
          end
          if (!hb && (hcount < HACT)) begin
            pix_out    <= front_pix;
            pix_opaque <= (front_pix[3:0] != 4'd0);
          end else begin
            pix_out    <= '0;
            pix_opaque <= 1'b0;
          end
`ifdef VBALL_SPRITE_PRIORITY_EN
          rmw_busy  <= accept;
          swap_pend <= swap_req && rmw_busy;
          if (accept) begin
            rmw_x   <= rnd.wr_x[7:0];
            rmw_pix <= rnd.wr_pix;
            rmw_ok  <= wr_keep;
          end
`endif
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vball_sprite_linebuf.sv
// Self-checking bench for vball_sprite_linebuf. Timing signals are driven
// directly; scanned pixels are checked against an expected-bank image through
// a scoreboard queue. Honours VBALL_SPRITE_PRIORITY_EN for write priority.
module tb_vball_sprite_linebuf;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hcount, vcount;
  logic       hb, flip;
  logic [7:0] pix_out;
  logic       pix_opaque;

  vball_sprite_linebuf_if #(.PIXW(8)) bus ();

  vball_sprite_linebuf #(
    .HACTIVE(240), .VACTIVE(240), .VTOTAL(262), .PIXW(8)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hb(hb), .flip(flip), .rnd(bus),
    .pix_out(pix_out), .pix_opaque(pix_opaque)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] x;
    logic [7:0] pix;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_bank [2][256];
  logic       sel_m;
  logic [7:0] exp_q [$];
  vec_t       tbl [10];

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sel_m = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++)
        exp_bank[b][a] = 8'h00;
  endtask

  // One renderer pixel write with a bounded wait for the handshake.
  task automatic apply_stimulus(input logic [8:0] x, input logic [7:0] pix);
    int waited = 0;
    bit done = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_x     = x;
    bus.wr_pix   = pix;
    while (!done && waited < 8) begin
      #1;
      if (bus.wr_ready) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.wr_valid = 1'b0;
    if (!done) check_output("wr_ready timeout", 0, 1);
  endtask

  // Scan one active line plus one out-of-range hcount, checking every pixel.
  task automatic scan_line(input logic fl);
    logic [7:0] a;
    logic [7:0] e;
    flip = fl;
    for (int h = 0; h <= 240; h++) begin
      hcount = 9'(h);
      hb     = 1'b0;
      a      = fl ? 8'(239 - h) : 8'(h);
      e      = (h < 240) ? exp_bank[sel_m][a] : 8'h00;
      exp_bank[sel_m][a] = 8'h00;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      check_output($sformatf("pix_out h=%0d flip=%0d", h, fl), int'(pix_out), int'(e));
      check_output($sformatf("pix_opaque h=%0d", h), int'(pix_opaque), int'(e[3:0] != 4'd0));
    end
  endtask

  // Raise hb at the given vcount and check the swap / line_start behaviour.
  task automatic swap_line(input logic [8:0] vc);
    logic [8:0] y;
    hb     = 1'b1;
    vcount = vc;
    #1;
    check_output("wr_ready in swap cycle", int'(bus.wr_ready), 0);
    @(posedge clk);
    #1;
    sel_m = ~sel_m;
    y = (vc == 9'd261) ? 9'd0 : vc + 9'd1;
    check_output($sformatf("line_start vc=%0d", vc), int'(bus.line_start), int'(y < 9'd240));
    if (y < 9'd240) check_output($sformatf("line_y vc=%0d", vc), int'(bus.line_y), int'(y));
    check_output("pix_out in hblank", int'(pix_out), 0);
    tick();
    check_output("line_start pulse end", int'(bus.line_start), 0);
    check_output("wr_ready after swap", int'(bus.wr_ready), 1);
  endtask

  // Count CLEAR cycles after reset release.
  task automatic count_clear();
    int n = 0;
    while (!bus.wr_ready && n < 300) begin
      n++;
      tick();
    end
    check_output("clear cycles", n, 256);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef VBALL_SPRITE_PRIORITY_EN
    tbl[0] = '{9'd10,  8'h3A, 1'b1, 8'h3A};
    tbl[1] = '{9'd20,  8'h51, 1'b0, 8'h00};
    tbl[2] = '{9'd20,  8'h72, 1'b0, 8'h00};
    tbl[3] = '{9'd20,  8'h40, 1'b1, 8'h51};
    tbl[4] = '{9'd250, 8'h5C, 1'b0, 8'h00};
    tbl[5] = '{9'd0,   8'h22, 1'b1, 8'h22};
    tbl[6] = '{9'd239, 8'h91, 1'b1, 8'h91};
    tbl[7] = '{9'd100, 8'h0F, 1'b0, 8'h00};
    tbl[8] = '{9'd100, 8'h03, 1'b1, 8'h0F};
    tbl[9] = '{9'd101, 8'hF0, 1'b1, 8'h00};
`else
    tbl[0] = '{9'd10,  8'h3A, 1'b1, 8'h3A};
    tbl[1] = '{9'd20,  8'h51, 1'b0, 8'h00};
    tbl[2] = '{9'd20,  8'h72, 1'b0, 8'h00};
    tbl[3] = '{9'd20,  8'h40, 1'b1, 8'h72};
    tbl[4] = '{9'd250, 8'h5C, 1'b0, 8'h00};
    tbl[5] = '{9'd0,   8'h22, 1'b1, 8'h22};
    tbl[6] = '{9'd239, 8'h91, 1'b1, 8'h91};
    tbl[7] = '{9'd100, 8'h0F, 1'b0, 8'h00};
    tbl[8] = '{9'd100, 8'h03, 1'b1, 8'h03};
    tbl[9] = '{9'd101, 8'hF0, 1'b1, 8'h00};
`endif

    reset        = 1'b1;
    hb           = 1'b1;
    hcount       = 9'd0;
    vcount       = 9'd0;
    flip         = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_x     = 9'd0;
    bus.wr_pix   = 8'h00;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset pix_out", int'(pix_out), 0);
    check_output("reset pix_opaque", int'(pix_opaque), 0);
    check_output("reset line_start", int'(bus.line_start), 0);
    check_output("reset line_y", int'(bus.line_y), 0);
    count_clear();

    // Both banks read back as zero after CLEAR.
    scan_line(1'b0);
    swap_line(9'd4);

    // Table-driven writes into the back bank, checked after the next swap.
    for (int i = 0; i < 10; i++) apply_stimulus(tbl[i].x, tbl[i].pix);
    for (int i = 0; i < 10; i++)
      if (tbl[i].chk) exp_bank[~sel_m][tbl[i].x[7:0]] = tbl[i].exp;
    tick();
    scan_line(1'b0);
    swap_line(9'd238);
    scan_line(1'b0);
    swap_line(9'd239);
    scan_line(1'b0);
    swap_line(9'd250);
    scan_line(1'b0);
    swap_line(9'd261);

    // Flipped scan: x=10 appears in the cycle after hcount=229.
    apply_stimulus(9'd10, 8'h3A);
    exp_bank[~sel_m][10] = 8'h3A;
    tick();
    scan_line(1'b0);
    swap_line(9'd260);
    scan_line(1'b1);
    swap_line(9'd5);

    // Reset mid-line with a write pending.
    apply_stimulus(9'd50, 8'h44);
    tick();
    hcount       = 9'd100;
    hb           = 1'b0;
    flip         = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_x     = 9'd60;
    bus.wr_pix   = 8'h77;
    reset        = 1'b1;
    #1;
    check_output("wr_ready during reset", int'(bus.wr_ready), 0);
    tick();
    check_output("pix_out after mid-line reset", int'(pix_out), 0);
    check_output("line_start after mid-line reset", int'(bus.line_start), 0);
    check_output("wr_ready after mid-line reset", int'(bus.wr_ready), 0);
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    hb           = 1'b1;
    clear_model();
    count_clear();
    scan_line(1'b0);
    swap_line(9'd10);
    scan_line(1'b0);

    // Normal operation resumes after the reset.
    swap_line(9'd20);
    apply_stimulus(9'd77, 8'h19);
    exp_bank[~sel_m][77] = 8'h19;
    tick();
    scan_line(1'b0);
    swap_line(9'd21);
    scan_line(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
